lorenz_step_ctrl: RTL and testbench

LORENZ_STEP_CTRL -- requirements
Module: lorenz_step_ctrl

---
 rtl/lorenz_pkg.sv | 15 +
 rtl/step_timer.sv | 35 +++
 rtl/lorenz_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_lorenz_step_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lorenz_pkg.sv
// Shared definitions for the Lorenz step controller: FSM state encoding
// and the default word widths and settle time.
package lorenz_pkg;
   localparam int N_DEF      = 32;
   localparam int CW_DEF     = 16;
   localparam int SETTLE_DEF = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_HOLD,
      ST_DONE
   } state_e;
endpackage

// File: rtl/step_timer.sv
// Step interval timer: counts cycles while run_i is high and flags the
// last cycle of a step period (cnt == per-1).
module step_timer
   import lorenz_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          run_i,
   input  logic [CW-1:0] per_i,
   output logic          tc_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == per_i - CW'(1));
endmodule

// File: rtl/lorenz_step_ctrl.sv
// Run controller for an external Euler-stepped Lorenz datapath: paces the
// commit pulse, captures each new state and hands it to a ready/valid consumer.
module lorenz_step_ctrl
   import lorenz_pkg::*;
#(
   parameter int n      = N_DEF,
   parameter int CW     = CW_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [CW-1:0] period,
   input  logic [CW-1:0] nsteps,
   output logic          load_init,
   output logic          en,
   input  logic [n-1:0]  x_in,
   input  logic [n-1:0]  y_in,
   input  logic [n-1:0]  z_in,
   output logic [n-1:0]  smp_x,
   output logic [n-1:0]  smp_y,
   output logic [n-1:0]  smp_z,
   output logic          smp_valid,
   input  logic          smp_ready,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] step_cnt
);
   localparam logic [CW-1:0] SETTLE_W = CW'(SETTLE);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_e        state_q, state_d;
   logic [CW-1:0] per_q, per_d;
   logic [CW-1:0] lim_q, lim_d;
   logic [CW-1:0] step_q, step_d;
   logic          cap_q;
   logic          vld_q, vld_d;
   logic [n-1:0]  smp_x_q, smp_y_q, smp_z_q;
   logic          en_c;
   logic          tmr_clr, tmr_run, tmr_tc;
   logic          lim_hit;

   step_timer #(.CW(CW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (tmr_clr),
      .run_i (tmr_run),
      .per_i (per_q),
      .tc_o  (tmr_tc)
   );

   assign lim_hit = (lim_q != '0) && (step_q == lim_q);

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      lim_d   = lim_q;
      step_d  = step_q;
      en_c    = 1'b0;
      tmr_clr = 1'b0;
      tmr_run = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            per_d   = (period < SETTLE_W) ? SETTLE_W : period;
            lim_d   = nsteps;
            step_d  = '0;
            tmr_clr = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // The final commit's capture lands on the same edge that leaves RUN.
            if (stop || lim_hit) begin
               state_d = ST_DONE;
            end else if (!tmr_tc) begin
               tmr_run = 1'b1;
            end else if (!vld_q || smp_ready) begin
               en_c = 1'b1;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d = ST_DONE;
            end else if (smp_ready) begin
               en_c    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase

      if (en_c) begin
         tmr_clr = 1'b1;
         step_d  = (step_q == CNT_MAX) ? step_q : step_q + CW'(1);
      end
   end

   // A capture in the same cycle as a handshake keeps the sample valid.
   always_comb begin
      vld_d = vld_q;
      if (state_q == ST_LOAD) begin
         vld_d = 1'b0;
      end else if (cap_q) begin
         vld_d = 1'b1;
      end else if (vld_q && smp_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         lim_q   <= '0;
         step_q  <= '0;
         cap_q   <= 1'b0;
         vld_q   <= 1'b0;
         smp_x_q <= '0;
         smp_y_q <= '0;
         smp_z_q <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         lim_q   <= lim_d;
         step_q  <= step_d;
         cap_q   <= en;
         vld_q   <= vld_d;
         if (cap_q) begin
            smp_x_q <= x_in;
            smp_y_q <= y_in;
            smp_z_q <= z_in;
         end
      end
   end

   // Gating with rst keeps a reset cycle from committing the datapath.
   assign en        = en_c && rst;
   assign load_init = (state_q == ST_LOAD) && rst;
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign done      = (state_q == ST_DONE);
   assign step_cnt  = step_q;
   assign smp_x     = smp_x_q;
   assign smp_y     = smp_y_q;
   assign smp_z     = smp_z_q;
   assign smp_valid = vld_q;
endmodule

// File: tb/tb_lorenz_step_ctrl.sv
// Scoreboard bench for lorenz_step_ctrl: an event-level model predicts commit
// times and sample values; a negedge monitor checks what the DUT presents.
module tb_lorenz_step_ctrl;
   localparam int N      = 32;
   localparam int CW     = 8;
   localparam int SETTLE = 6;
   localparam int CMAX   = (1 << CW) - 1;
   localparam logic [95:0] INIT = {32'h0000_1000, 32'h0000_0200, 32'h0000_0030};

   logic          clk = 1'b0;
   logic          rst, start, stop, smp_ready;
   logic [CW-1:0] period, nsteps;
   logic          load_init, en, smp_valid, busy, done;
   logic [N-1:0]  px = '0, py = '0, pz = '0;
   logic [N-1:0]  smp_x, smp_y, smp_z;
   logic [CW-1:0] step_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int run_L = 0;
   bit rdy_rel [512];
   int en_q [$];
   int ld_q [$];
   logic [95:0] qs [$];
   logic        stall_q = 1'b0;
   logic [95:0] hold_v = '0;

   lorenz_step_ctrl #(.n(N), .CW(CW), .SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .period    (period),
      .nsteps    (nsteps),
      .load_init (load_init),
      .en        (en),
      .x_in      (px),
      .y_in      (py),
      .z_in      (pz),
      .smp_x     (smp_x),
      .smp_y     (smp_y),
      .smp_z     (smp_z),
      .smp_valid (smp_valid),
      .smp_ready (smp_ready),
      .busy      (busy),
      .done      (done),
      .step_cnt  (step_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [95:0] step_f(input logic [95:0] s);
      logic [31:0] x, y, z;
      x = s[95:64];
      y = s[63:32];
      z = s[31:0];
      return {x + (y >> 2) + 32'd7, y - (x >> 3) + z, z ^ {x[15:0], y[31:16]}};
   endfunction

   // External state registers that the controller drives.
   always @(posedge clk) begin
      if (load_init) begin
         {px, py, pz} <= INIT;
      end else if (en) begin
         {px, py, pz} <= step_f({px, py, pz});
      end
   end

   function automatic bit rdy_at(input int c);
      int rel;
      rel = c - run_L;
      if (rel < 0 || rel > 511) return 1'b1;
      return rdy_rel[rel];
   endfunction

   task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      failures++;
      $display("FAIL %s got=unexpected event exp=none (cycle %0d)", nm, cyc);
   endtask

   always @(negedge clk) begin
      if (en) begin
         if (en_q.size() == 0) flag("en_extra");
         else chk("en_time", 96'(cyc), 96'(en_q.pop_front()));
      end
      if (load_init) begin
         if (ld_q.size() == 0) flag("load_init_extra");
         else chk("load_init_time", 96'(cyc), 96'(ld_q.pop_front()));
      end
      if (smp_valid && smp_ready) begin
         if (qs.size() == 0) flag("sample_extra");
         else chk("sample", {smp_x, smp_y, smp_z}, qs.pop_front());
      end
      if (stall_q && rst) chk("hold_stable", {smp_x, smp_y, smp_z}, hold_v);
      stall_q <= rst && smp_valid && !smp_ready;
      hold_v  <= {smp_x, smp_y, smp_z};
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_en"}, 96'(en), 96'(0));
      chk({tag, "_load_init"}, 96'(load_init), 96'(0));
      chk({tag, "_smp_valid"}, 96'(smp_valid), 96'(0));
      chk({tag, "_busy"}, 96'(busy), 96'(0));
      chk({tag, "_done"}, 96'(done), 96'(0));
      chk({tag, "_step_cnt"}, 96'(step_cnt), 96'(0));
      chk({tag, "_smp"}, {smp_x, smp_y, smp_z}, 96'(0));
   endtask

   // rmode: 0 ready always, 1 random, 2 low for 30 cycles, 3 low for 60 cycles.
   task automatic run_case(input int per, input int ns, input int stop_rel,
                           input int rst_rel, input int rmode, input int rs_rel);
      int pe, k, e, h, abort, t0, exp_cnt, n_cyc;
      logic [95:0] s;
      bit fin;
      pe = (per < SETTLE) ? SETTLE : per;
      for (int i = 0; i < 512; i++) begin
         case (rmode)
            0:       rdy_rel[i] = 1'b1;
            1:       rdy_rel[i] = 1'($urandom_range(0, 1));
            2:       rdy_rel[i] = (i >= 30);
            default: rdy_rel[i] = (i >= 60);
         endcase
      end
      @(posedge clk);
      #1;
      t0 = cyc;
      run_L = t0 + 1;
      abort = 1 << 30;
      if (stop_rel >= 0) abort = run_L + stop_rel;
      if (rst_rel >= 0) abort = run_L + rst_rel;
      // Commit k+1 comes pe cycles after commit k, or later once sample k is taken.
      ld_q.push_back(run_L);
      s = INIT;
      k = 0;
      e = run_L + pe;
      while (!(ns != 0 && k == ns) && e < abort && k < 1000) begin
         en_q.push_back(e);
         s = step_f(s);
         qs.push_back(s);
         h = e + 2;
         while (!rdy_at(h)) h++;
         k++;
         e = (e + pe > h) ? e + pe : h;
      end
      exp_cnt = (k > CMAX) ? CMAX : k;
      period = CW'(per);
      nsteps = CW'(ns);
      start = 1'b1;
      stop = 1'b0;
      rst = 1'b1;
      smp_ready = rdy_at(t0);
      fin = 1'b0;
      n_cyc = 0;
      while (!fin) begin
         @(posedge clk);
         #1;
         n_cyc++;
         start = (rs_rel >= 0 && cyc == run_L + rs_rel);
         stop = (stop_rel >= 0 && cyc == abort);
         rst = !(rst_rel >= 0 && cyc == abort);
         smp_ready = rdy_at(cyc);
         if (rst_rel >= 0 && cyc == abort + 1) begin
            chk_zero("after_reset");
            chk("reset_pending_en", 96'(en_q.size()), 96'(0));
            chk("reset_pending_smp", 96'(qs.size()), 96'(k));
            qs.delete();
            fin = 1'b1;
         end else if (rst_rel < 0 && done && en_q.size() == 0 && qs.size() == 0 && ld_q.size() == 0) begin
            chk("final_step_cnt", 96'(step_cnt), 96'(exp_cnt));
            chk("final_busy", 96'(busy), 96'(0));
            chk("final_smp_valid", 96'(smp_valid), 96'(0));
            fin = 1'b1;
         end else if (n_cyc > 4000) begin
            flag("run_timeout");
            en_q.delete();
            ld_q.delete();
            qs.delete();
            fin = 1'b1;
         end
      end
      start = 1'b0;
      stop = 1'b0;
      rst = 1'b1;
      smp_ready = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      smp_ready = 1'b1;
      period = '0;
      nsteps = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b1;

      // start and stop together in IDLE must not begin a run
      @(posedge clk);
      #1;
      start = 1'b1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      chk("idle_startstop_busy", 96'(busy), 96'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("idle_startstop_busy_later", 96'(busy), 96'(0));

      run_case(10, 3, -1, -1, 0, -1);
      run_case(2, 4, -1, -1, 0, -1);
      run_case(8, 3, -1, -1, 2, -1);
      run_case(10, 0, 35, -1, 0, -1);
      run_case(10, 4, -1, -1, 0, 5);
      run_case(8, 0, -1, 22, 3, -1);
      run_case(7, 2, -1, -1, 0, -1);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) run_case(int'($urandom_range(0, 12)), int'($urandom_range(1, 5)), -1, -1, 1, -1);
         else run_case(int'($urandom_range(0, 12)), 0, int'($urandom_range(15, 90)), -1, 1, -1);
      end
      run_case(2, 0, 6 * 258 + 3, -1, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
